fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction fetch and issue controller between the program RAM and the multicycle 16-bit processor core. It holds the program counter and drives the RAM address. It captures instruction words, and the immediate word for `mvi`, across the RAM's one-cycle read latency. It presents each word on the core's `DIN` with `Run` asserted, then waits for the core's `Done` before advancing.

## Interface
Parameters:
- `ADDR_W`, default 5: program address width; PC wraps modulo 2^ADDR_W.
- `HALT_WORD`, default 16'hFFFF: instruction word that halts sequencing.
- `TIMEOUT`, default 7: maximum EXEC cycles allowed without `Done`.

Ports:
- `Clock`  in  1: single clock, rising edge.
- `Resetn`  in  1: synchronous, active-low reset.
- `Run`  in  1: enables sequencing; sampled at instruction boundaries.
- `Step`  in  1: single-step request; used only with `FETCH_STEP_EN`.
- `MemData`  in  16: RAM output; valid one cycle after `Addr` is presented.
- `Done`  in  1: core instruction-complete strobe, combinational from the core.
- `Addr`  out  ADDR_W: RAM read address.
- `DinOut`  out  16: word driven to the core's `DIN`.
- `ProcRun`  out  1: run/issue qualifier to the core.
- `PC`  out  ADDR_W: current program counter.
- `State`  out  3: state encoding, for display.
- `Halted`  out  1: `HALT_WORD` was fetched.
- `Fault`  out  1: `Done` timeout; sticky until reset.

## Operation
- States: IDLE, FETCH_I, WAIT_I, FETCH_D, WAIT_D, ISSUE, EXEC, HALT. FAULT is an additional state.
- IDLE: if `Run`=1, go to FETCH_I.
- FETCH_I: `Addr`=PC. Go to WAIT_I.
- WAIT_I: capture `MemData` into the instruction register (`instr`).
  - If `MemData`==`HALT_WORD`, go to HALT.
  - Else if `MemData[8:6]`==3'b001 (`mvi`), go to FETCH_D.
  - Else go to ISSUE.
- FETCH_D: `Addr`=PC+1, with wrap. Go to WAIT_D.
- WAIT_D: capture `MemData` into the immediate register (`imm`). Go to ISSUE.
- ISSUE: `DinOut`=`instr`, `ProcRun`=1. The core latches IR at the end of this cycle. Go to EXEC.
- EXEC: `DinOut`=`imm` if the instruction is `mvi`, else `instr`. `ProcRun`=1.
  - On `Done`=1: PC += 2 for `mvi`, else PC += 1, with wrap. Clear the timeout count. Go to FETCH_I if `Run`=1, else IDLE.
  - If `TIMEOUT` EXEC cycles elapse without `Done`: go to FAULT.
- HALT and FAULT are absorbing; only `Resetn` exits them. `Halted`=1 in HALT; `Fault`=1 in FAULT. `ProcRun`=0 in both.
- `ProcRun`=0 in every state except ISSUE and EXEC.
- `Addr`=PC in every state except FETCH_D and WAIT_D, where it is PC+1.
- `DinOut`=`instr` in every state except EXEC with `mvi`.

## Timing
- Reset: PC=0, `instr`=0, `imm`=0, timeout count=0, State=IDLE. Outputs: `Addr`=0, `DinOut`=0, `ProcRun`=0, `Halted`=0, `Fault`=0.
- Reset is taken on any edge with `Resetn`=0, including mid-instruction. No partial PC update occurs.
- Latency from FETCH_I entry to the `Done` edge:
  - `mv`: 4 cycles.
  - ALU ops: 6 cycles.
  - `mvi`: 6 cycles.
- `Run` falling mid-instruction: the current instruction completes, then the block goes to IDLE. `Run` is not re-sampled until IDLE.
- `Done` outside EXEC is ignored.
- `mvi` at address 2^ADDR_W−1: the immediate is read from address 0, and PC becomes 1.
- `Done` and timeout expiry in the same cycle: `Done` wins.

## Configuration
- Macro `FETCH_STEP_EN`.
- Defined:
  - After each `Done`, go to IDLE regardless of `Run`.
  - Leave IDLE only on a rising edge of `Step` while `Run`=1.
  - Rising edge = registered `Step` was 0 and current `Step` is 1.
  - A `Step` edge during any other state is discarded.
- Undefined: `Step` is ignored and the edge register is not built. Free-running behaviour is as described above.

## Structure
- Package `fetch_pkg` contains:
  - the state enumeration and its 3-bit encodings (IDLE=0 … FAULT=7);
  - `OP_MVI`=3'b001;
  - the default `HALT_WORD`.
- Sub-module `rise_detect` (1-bit registered edge detector, synchronous active-low reset), instantiated only under `FETCH_STEP_EN`.
- Everything else (state register, PC, `instr`/`imm` registers, timeout counter) lives in the top module.

## Test plan
- Program `mvi R0,#5` (RAM[0]=16'h0040, RAM[1]=16'h0005), then `HALT_WORD` at RAM[2], with `Run`=1. Expected:
  - `DinOut`=16'h0040 in ISSUE and 16'h0005 in EXEC;
  - PC=2;
  - `Halted`=1 one cycle after WAIT_I of address 2.
- `add R1,R2` (16'h008A) with a model core. Expected: `Done` on the 3rd EXEC cycle; PC 0→1 in 6 cycles total; FETCH_I re-entered.
- `Done` held 0 during EXEC. Expected: FAULT after exactly 7 EXEC cycles, `Fault`=1, `ProcRun`=0; a later `Done`=1 has no effect.
- `mvi` placed at address 31 (`ADDR_W`=5). Expected: immediate read from `Addr`=0; PC wraps to 1.
- `Run` dropped during EXEC of `mv` (16'h0000). Expected: `Done` advances PC to 1 and the block goes to IDLE. `Resetn`=0 during EXEC returns all outputs to their reset values on the next edge.
- With `FETCH_STEP_EN`, `Run`=1: exactly one instruction runs per `Step` pulse; holding `Step` high does not run a second instruction.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/issue sequencer.
package fetch_pkg;

  // HALT and FAULT share display code 7; the top distinguishes them with a sticky fault flag.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetchI = 3'd1,
    StWaitI  = 3'd2,
    StFetchD = 3'd3,
    StWaitD  = 3'd4,
    StIssue  = 3'd5,
    StExec   = 3'd6,
    StStop   = 3'd7
  } state_e;

  localparam logic [2:0]  OP_MVI            = 3'b001;
  localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

  function automatic logic is_mvi(input logic [15:0] word);
    return word[8:6] == OP_MVI;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector with synchronous active-low reset.
module rise_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue controller between program RAM and the multicycle core.
// Optional single-step mode is enabled by defining FETCH_STEP_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 5,
  parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT,
  parameter int unsigned TIMEOUT   = 7
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic              Step,
  input  logic [15:0]       MemData,
  input  logic              Done,
  output logic [ADDR_W-1:0] Addr,
  output logic [15:0]       DinOut,
  output logic              ProcRun,
  output logic [ADDR_W-1:0] PC,
  output logic [2:0]        State,
  output logic              Halted,
  output logic              Fault
);

  localparam int unsigned   TmoW    = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       imm_q, imm_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              fault_q, fault_d;

  logic              start;
  logic              keep_going;
  logic              cur_mvi;
  logic [ADDR_W-1:0] pc_next;

`ifdef FETCH_STEP_EN
  logic step_rise;

  rise_detect u_step_rise (
    .clk_i  (Clock),
    .rst_ni (Resetn),
    .d_i    (Step),
    .rise_o (step_rise)
  );

  // Each Step pulse runs exactly one instruction, then control returns to IDLE.
  assign start      = Run & step_rise;
  assign keep_going = 1'b0;
`else
  logic unused_step;

  assign unused_step = Step;
  assign start       = Run;
  assign keep_going  = Run;
`endif

  assign cur_mvi = is_mvi(instr_q);
  assign pc_next = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    imm_d   = imm_q;
    tmo_d   = tmo_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetchI;
      end
      StFetchI: state_d = StWaitI;
      StWaitI: begin
        instr_d = MemData;
        if (MemData == HALT_WORD) begin
          state_d = StStop;
        end else if (is_mvi(MemData)) begin
          state_d = StFetchD;
        end else begin
          state_d = StIssue;
        end
      end
      StFetchD: state_d = StWaitD;
      StWaitD: begin
        imm_d   = MemData;
        state_d = StIssue;
      end
      StIssue: state_d = StExec;
      StExec: begin
        // Done takes priority over an expiring timeout in the same cycle.
        if (Done) begin
          pc_d    = cur_mvi ? pc_q + ADDR_W'(2) : pc_next;
          tmo_d   = '0;
          state_d = keep_going ? StFetchI : StIdle;
        end else if (tmo_q == TmoLast) begin
          fault_d = 1'b1;
          state_d = StStop;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StStop: state_d = StStop;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
      imm_q   <= '0;
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    Addr    = pc_q;
    DinOut  = instr_q;
    ProcRun = 1'b0;
    unique case (state_q)
      StFetchD, StWaitD: Addr = pc_next;
      StIssue:           ProcRun = 1'b1;
      StExec: begin
        ProcRun = 1'b1;
        if (cur_mvi) DinOut = imm_q;
      end
      default: ;
    endcase
  end

  assign PC     = pc_q;
  assign State  = state_q;
  assign Halted = (state_q == StStop) & ~fault_q;
  assign Fault  = (state_q == StStop) & fault_q;

endmodule
